// File: rtl/uart_parity_engine.sv
// Parity and LRC block-check stage feeding the UART serializer.
// Masks each word to the active length, adds a parity bit, optionally appends a block LRC word.
module uart_parity_engine #(
  parameter int DATA_WIDTH = 8,
  parameter int FRAME_W    = 4,
  parameter int LEN_W      = $clog2(DATA_WIDTH + 1)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] IN_DATA,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  input  logic                  PAR_EN,
  input  logic [1:0]            PAR_MODE,
  input  logic [LEN_W-1:0]      DATA_LEN,
  input  logic [FRAME_W-1:0]    FRAME_LEN,
  output logic [DATA_WIDTH-1:0] OUT_DATA,
  output logic                  OUT_PAR,
  output logic                  OUT_LRC,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic                  BUSY
);

  typedef enum logic [1:0] {IDLE, ACCUM, EMIT} state_t;

  state_t                 state;
  logic [FRAME_W-1:0]     cnt;
  logic [DATA_WIDTH-1:0]  acc;
  logic                   cfg_par_en;
  logic [1:0]             cfg_par_mode;
  logic [LEN_W-1:0]       cfg_data_len;
  logic [FRAME_W-1:0]     cfg_frame_len;

  logic                   in_fire;
  logic                   out_free;
  logic                   sel_par_en;
  logic [1:0]             sel_par_mode;
  logic [LEN_W-1:0]       sel_data_len;
  logic [DATA_WIDTH-1:0]  masked;
  logic [FRAME_W:0]       cnt_inc;

  function automatic logic [DATA_WIDTH-1:0] mask_word(input logic [DATA_WIDTH-1:0] d,
                                                      input logic [LEN_W-1:0] len);
    logic [DATA_WIDTH-1:0] m;
    m = '0;
    for (int i = 0; i < DATA_WIDTH; i++)
      m[i] = (len == '0) || (int'(len) > DATA_WIDTH) || (i < int'(len));
    return d & m;
  endfunction

  function automatic logic parity_bit(input logic [DATA_WIDTH-1:0] d, input logic en,
                                      input logic [1:0] mode);
    logic p;
    p = 1'b0;
    if (en) begin
      case (mode)
        2'b00:   p = ^d;
        2'b01:   p = ~(^d);
        2'b10:   p = 1'b1;
        default: p = 1'b0;
      endcase
    end
    return p;
  endfunction

  // A word accepted in IDLE starts a block and must already use the incoming config.
  assign sel_par_en   = (state == IDLE) ? PAR_EN   : cfg_par_en;
  assign sel_par_mode = (state == IDLE) ? PAR_MODE : cfg_par_mode;
  assign sel_data_len = (state == IDLE) ? DATA_LEN : cfg_data_len;

  assign out_free = !OUT_VALID || OUT_READY;
  assign IN_READY = (state != EMIT) && out_free;
  assign in_fire  = IN_VALID && IN_READY;
  assign masked   = mask_word(IN_DATA, sel_data_len);
  assign cnt_inc  = {1'b0, cnt} + 1'b1;
  assign BUSY     = (state != IDLE) || OUT_VALID;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state         <= IDLE;
      cnt           <= '0;
      acc           <= '0;
      cfg_par_en    <= 1'b0;
      cfg_par_mode  <= '0;
      cfg_data_len  <= '0;
      cfg_frame_len <= '0;
      OUT_DATA      <= '0;
      OUT_PAR       <= 1'b0;
      OUT_LRC       <= 1'b0;
      OUT_VALID     <= 1'b0;
    end else begin
      if (in_fire) begin
        OUT_DATA  <= masked;
        OUT_PAR   <= parity_bit(masked, sel_par_en, sel_par_mode);
        OUT_LRC   <= 1'b0;
        OUT_VALID <= 1'b1;
      end else if (state == EMIT && out_free) begin
        OUT_DATA  <= acc;
        OUT_PAR   <= parity_bit(acc, cfg_par_en, cfg_par_mode);
        OUT_LRC   <= 1'b1;
        OUT_VALID <= 1'b1;
      end else if (OUT_VALID && OUT_READY) begin
        OUT_VALID <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (in_fire) begin
            cfg_par_en    <= PAR_EN;
            cfg_par_mode  <= PAR_MODE;
            cfg_data_len  <= DATA_LEN;
            cfg_frame_len <= FRAME_LEN;
            if (FRAME_LEN == FRAME_W'(1)) begin
              acc   <= masked;
              cnt   <= FRAME_W'(1);
              state <= EMIT;
            end else if (FRAME_LEN != '0) begin
              acc   <= masked;
              cnt   <= FRAME_W'(1);
              state <= ACCUM;
            end else begin
              acc <= '0;
              cnt <= '0;
            end
          end
        end
        ACCUM: begin
          if (in_fire) begin
            acc <= acc ^ masked;
            cnt <= cnt_inc[FRAME_W-1:0];
            if (cnt_inc == {1'b0, cfg_frame_len}) state <= EMIT;
          end
        end
        EMIT: begin
          if (out_free) begin
            acc   <= '0;
            cnt   <= '0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_parity_engine.sv
// Scoreboard bench for uart_parity_engine: directed scenarios plus randomized traffic
// checked against a word-level reference model of the block/parity rules.
module tb_uart_parity_engine;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [7:0] IN_DATA = '0;
  logic       IN_VALID = 1'b0;
  logic       IN_READY;
  logic       PAR_EN = 1'b0;
  logic [1:0] PAR_MODE = '0;
  logic [3:0] DATA_LEN = '0;
  logic [3:0] FRAME_LEN = '0;
  logic [7:0] OUT_DATA;
  logic       OUT_PAR;
  logic       OUT_LRC;
  logic       OUT_VALID;
  logic       OUT_READY;
  logic       BUSY;

  logic rdy_dir = 1'b1;
  logic rdy_rand = 1'b1;
  logic bp_en = 1'b0;
  assign OUT_READY = bp_en ? rdy_rand : rdy_dir;

  uart_parity_engine #(.DATA_WIDTH(8), .FRAME_W(4)) dut (
    .CLK(CLK), .RST(RST),
    .IN_DATA(IN_DATA), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .PAR_EN(PAR_EN), .PAR_MODE(PAR_MODE), .DATA_LEN(DATA_LEN), .FRAME_LEN(FRAME_LEN),
    .OUT_DATA(OUT_DATA), .OUT_PAR(OUT_PAR), .OUT_LRC(OUT_LRC),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    #1 rdy_rand = ($urandom_range(0, 3) != 0);
  end

  typedef struct packed {
    logic [7:0] d;
    logic       p;
    logic       l;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   rdy_low = 0;
  int   lrc_seen = 0;
  exp_t last_lrc;

  // Reference model: block state is just "words seen so far" and their running XOR.
  int         m_cnt = 0;
  logic [7:0] m_acc = '0;
  logic       m_en = 1'b0;
  logic [1:0] m_mode = '0;
  int         m_len = 0;
  int         m_frame = 0;

  function automatic logic [7:0] mdl_mask(input logic [7:0] d, input int len);
    int eff;
    eff = (len == 0 || len > 8) ? 8 : len;
    return 8'(int'(d) % (1 << eff));
  endfunction

  function automatic logic mdl_par(input logic [7:0] w, input logic en, input logic [1:0] mode);
    int ones;
    ones = $countones(w);
    if (!en) return 1'b0;
    case (mode)
      2'd0:    return (ones % 2) == 1;
      2'd1:    return (ones % 2) == 0;
      2'd2:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_accept(input logic [7:0] d);
    logic [7:0] w;
    if (m_cnt == 0) begin
      m_en    = PAR_EN;
      m_mode  = PAR_MODE;
      m_len   = int'(DATA_LEN);
      m_frame = int'(FRAME_LEN);
      m_acc   = '0;
    end
    w = mdl_mask(d, m_len);
    q.push_back('{d: w, p: mdl_par(w, m_en, m_mode), l: 1'b0});
    if (m_frame != 0) begin
      m_acc = m_acc ^ w;
      m_cnt++;
      if (m_cnt == m_frame) begin
        q.push_back('{d: m_acc, p: mdl_par(m_acc, m_en, m_mode), l: 1'b1});
        m_cnt = 0;
        m_acc = '0;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: pops the scoreboard on every output transfer and checks hold-under-stall.
  logic held_v = 1'b0;
  exp_t held;
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (!RST) begin
        held_v = 1'b0;
      end else begin
        if (!IN_READY) rdy_low++;
        if (held_v) begin
          checks++;
          if (OUT_VALID !== 1'b1 || {OUT_DATA, OUT_PAR, OUT_LRC} !== held) begin
            failures++;
            $display("FAIL hold actual=%0h/%0b required=%0h/1", {OUT_DATA, OUT_PAR, OUT_LRC},
                     OUT_VALID, held);
          end
        end
        if (OUT_VALID && OUT_READY) begin
          checks++;
          if (q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_out actual=%0h required=none", {OUT_DATA, OUT_PAR, OUT_LRC});
          end else begin
            e = q.pop_front();
            if ({OUT_DATA, OUT_PAR, OUT_LRC} !== e) begin
              failures++;
              $display("FAIL out_word actual=d%0h p%0b l%0b required=d%0h p%0b l%0b",
                       OUT_DATA, OUT_PAR, OUT_LRC, e.d, e.p, e.l);
            end
            if (e.l) begin
              lrc_seen++;
              last_lrc = e;
            end
          end
        end
        held_v = OUT_VALID && !OUT_READY;
        held   = {OUT_DATA, OUT_PAR, OUT_LRC};
      end
    end
  end

  task automatic send(input logic [7:0] d);
    int t;
    t = 0;
    IN_DATA  = d;
    IN_VALID = 1'b1;
    @(negedge CLK);
    while (!IN_READY && t < 200) begin
      t++;
      @(negedge CLK);
    end
    if (!IN_READY) begin
      chk("send_timeout", 32'(t), 32'(0));
      IN_VALID = 1'b0;
      return;
    end
    model_accept(d);
    @(posedge CLK);
    #1;
    IN_VALID = 1'b0;
    chk("latency_valid", {30'd0, OUT_VALID, OUT_LRC}, 32'b10);
  endtask

  task automatic set_cfg(input logic en, input logic [1:0] mode, input logic [3:0] len,
                         input logic [3:0] frame);
    PAR_EN = en;
    PAR_MODE = mode;
    DATA_LEN = len;
    FRAME_LEN = frame;
  endtask

  task automatic drain();
    int t;
    t = 0;
    bp_en = 1'b0;
    rdy_dir = 1'b1;
    while ((q.size() != 0 || BUSY) && t < 300) begin
      @(posedge CLK);
      #1;
      t++;
    end
    chk("drain_queue", 32'(q.size()), 32'(0));
    chk("drain_busy", {31'd0, BUSY}, 32'd0);
  endtask

  initial begin
    int base;
    int lrc_base;
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int lrc_base;
    #3;
    chk("reset_outputs", {OUT_DATA, OUT_PAR, OUT_LRC, OUT_VALID, BUSY}, 32'd0);
    repeat (2) @(posedge CLK);
    #1 RST = 1'b1;
    @(posedge CLK);
    #1;

    // Parity modes on 0xA5, then disabled parity.
    for (int m = 0; m < 4; m++) begin
      set_cfg(1'b1, 2'(m), 4'd8, 4'd0);
      send(8'hA5);
    end
    set_cfg(1'b0, 2'd1, 4'd8, 4'd0);
    send(8'hA5);

    // Masking.
    set_cfg(1'b1, 2'd0, 4'd7, 4'd0);
    send(8'h81);
    set_cfg(1'b1, 2'd0, 4'd0, 4'd0);
    send(8'h81);
    drain();

    // LRC block, back-to-back, exactly one not-ready cycle for the LRC slot.
    set_cfg(1'b1, 2'd0, 4'd8, 4'd3);
    base = rdy_low;
    lrc_base = lrc_seen;
    send(8'h01);
    send(8'h02);
    send(8'h04);
    repeat (4) @(negedge CLK);
    chk("emit_ready_low", 32'(rdy_low - base), 32'd1);
    chk("lrc3_seen", 32'(lrc_seen - lrc_base), 32'd1);
    chk("lrc3_word", {23'd0, last_lrc}, {23'd0, 8'h07, 1'b1, 1'b1});
    @(posedge CLK);
    #1;
    drain();

    // Backpressure with a mid-block mode change.
    set_cfg(1'b1, 2'd0, 4'd8, 4'd2);
    rdy_dir = 1'b0;
    send(8'h03);
    PAR_MODE = 2'd1;
    IN_DATA = 8'h05;
    IN_VALID = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      chk("stall_in_ready", {31'd0, IN_READY}, 32'd0);
    end
    @(posedge CLK);
    #1 rdy_dir = 1'b1;
    send(8'h05);
    drain();

    // Reset mid-block discards everything.
    set_cfg(1'b1, 2'd0, 4'd8, 4'd4);
    send(8'h11);
    send(8'h22);
    RST = 1'b0;
    #1;
    chk("midreset_outputs", {OUT_DATA, OUT_PAR, OUT_LRC, OUT_VALID, BUSY}, 32'd0);
    q.delete();
    m_cnt = 0;
    m_acc = '0;
    @(posedge CLK);
    #1 RST = 1'b1;
    @(posedge CLK);
    #1;
    lrc_base = lrc_seen;
    send(8'h10);
    send(8'h20);
    send(8'h40);
    send(8'h80);
    drain();
    chk("reset_block_lrc", {23'd0, last_lrc}, {23'd0, 8'hF0, 1'b0, 1'b1});
    chk("reset_block_cnt", 32'(lrc_seen - lrc_base), 32'd1);

    // Maximum block length.
    set_cfg(1'b1, 2'd0, 4'd8, 4'd15);
    lrc_base = lrc_seen;
    for (int i = 0; i < 15; i++) begin
      send(8'hFF);
      if (i < 14) chk("max_no_early_lrc", 32'(lrc_seen - lrc_base), 32'd0);
    end
    drain();
    chk("max_lrc", {23'd0, last_lrc}, {23'd0, 8'hFF, 1'b0, 1'b1});
    set_cfg(1'b1, 2'd1, 4'd8, 4'd2);
    send(8'h0F);
    send(8'hF1);
    drain();

    // Randomized traffic with random backpressure and config churn.
    bp_en = 1'b1;
    for (int n = 0; n < 300; n++) begin
      set_cfg(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
              ($urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(0, 5)));
      send(8'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge CLK);
        #1;
      end
    end
    // Close any open block with single-length words so every LRC is observed.
    set_cfg(1'b1, 2'd0, 4'd8, 4'd1);
    for (int n = 0; n < 15 && m_cnt != 0; n++) send(8'($urandom));
    drain();
    chk("final_model_idle", 32'(m_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_parity_engine.md
Name: uart_parity_engine

Overview:
- Parametrised parity and block-check stage between the TX data source and the UART serializer.
- Accepts words over a valid/ready handshake and masks each word to a runtime-selected data length.
- Computes a per-word parity bit in one of four modes.
- Optionally appends a longitudinal redundancy check (LRC) word, the XOR of all words in a block, after every FRAME_LEN words.
- One-deep registered output stage with backpressure; configuration is latched per block.

Parameters:
- DATA_WIDTH, 8, maximum data bits per word.
- FRAME_W, 4, width of FRAME_LEN; maximum block length is 2^FRAME_W-1 words.
- LEN_W, $clog2(DATA_WIDTH+1), width of DATA_LEN.

Ports:
- CLK  in  1  clock.
- RST  in  1  reset, asynchronous, active-low.
- IN_DATA  in  DATA_WIDTH  input word.
- IN_VALID  in  1  input word valid.
- IN_READY  out  1  engine can accept a word this cycle.
- PAR_EN  in  1  parity enable; 0 forces OUT_PAR=0.
- PAR_MODE  in  2  00 even, 01 odd, 10 mark (1), 11 space (0).
- DATA_LEN  in  LEN_W  active data bits per word; 0 or >DATA_WIDTH means DATA_WIDTH.
- FRAME_LEN  in  FRAME_W  words per LRC block; 0 disables LRC.
- OUT_DATA  out  DATA_WIDTH  masked data word or LRC word.
- OUT_PAR  out  1  parity bit for OUT_DATA.
- OUT_LRC  out  1  OUT_DATA is an LRC word.
- OUT_VALID  out  1  output stage holds a word.
- OUT_READY  in  1  downstream accepts the output word.
- BUSY  out  1  a block is in progress or the output stage is occupied.

Behaviour:
- Reset (RST low, asynchronous):
  - OUT_DATA=0, OUT_PAR=0, OUT_LRC=0, OUT_VALID=0, BUSY=0.
  - Word counter=0, LRC accumulator=0, latched config=0, state IDLE.
  - Reset mid-block discards the partial block; no LRC word is emitted.
- Handshakes:
  - Input transfer when IN_VALID && IN_READY.
  - Output transfer when OUT_VALID && OUT_READY.
  - IN_READY = (state != EMIT) && (!OUT_VALID || OUT_READY).
  - OUT_DATA, OUT_PAR and OUT_LRC hold stable while OUT_VALID && !OUT_READY.
- Latency: an accepted word appears on the output the next cycle with OUT_VALID=1. Full throughput is one word per cycle when OUT_READY is held high.
- Config latch:
  - PAR_EN, PAR_MODE, DATA_LEN and FRAME_LEN are captured on the input transfer made in IDLE, and that word uses the newly captured values.
  - The captured values are held until the block ends. Input changes mid-block are ignored.
  - With FRAME_LEN=0, every word is latched independently, as a block of one word with no LRC.
- Masking: OUT_DATA = IN_DATA with bits [DATA_WIDTH-1:L] cleared, where L is the effective length.
- Parity: P = XOR of the masked word.
  - Even mode: OUT_PAR = P.
  - Odd mode: OUT_PAR = ~P.
  - Mark mode: OUT_PAR = 1.
  - Space mode: OUT_PAR = 0.
  - PAR_EN=0: OUT_PAR = 0.
- States:
  - IDLE: counter=0. An input transfer latches config, sets acc = masked word and sets counter=1. If FRAME_LEN=1 (latched), go to EMIT; else if FRAME_LEN>1, go to ACCUM; else (LRC disabled) stay in IDLE with counter=0.
  - ACCUM: each input transfer does acc ^= masked word and counter++. When counter reaches FRAME_LEN, go to EMIT.
  - EMIT: IN_READY=0. Once the output stage is free (!OUT_VALID || OUT_READY), load OUT_DATA=acc, OUT_PAR=parity(acc) using the latched mode, OUT_LRC=1 and OUT_VALID=1. Then clear acc and counter and go to IDLE.
- Simultaneous events: an output transfer and a new load in the same cycle are legal and produce no bubble. The EMIT load may coincide with the output transfer of the last data word.
- BUSY = (state != IDLE) || OUT_VALID.
- Arithmetic: the counter is FRAME_W bits. FRAME_LEN = 2^FRAME_W-1 must not wrap the counter before the compare.

Test Plan:
- Parity modes: PAR_EN=1, DATA_LEN=8, FRAME_LEN=0, IN_DATA=0xA5 sent in modes 00/01/10/11 -> OUT_PAR=0/1/1/0. Same word with PAR_EN=0 -> OUT_PAR=0. OUT_LRC=0 each time, one cycle after acceptance.
- Masking: DATA_LEN=7, even mode, IN_DATA=0x81 -> OUT_DATA=0x01, OUT_PAR=1. DATA_LEN=0, IN_DATA=0x81 -> OUT_DATA=0x81, OUT_PAR=0.
- LRC block: FRAME_LEN=3, even mode, words 0x01,0x02,0x04 back-to-back with OUT_READY=1 -> outputs 0x01/1, 0x02/1, 0x04/1, then 0x07 with OUT_PAR=1 and OUT_LRC=1. IN_READY=0 for exactly one cycle during EMIT.
- Backpressure plus config change: FRAME_LEN=2, hold OUT_READY=0 for 5 cycles after the first word; toggle PAR_MODE to odd mid-block -> OUT_DATA is stable, IN_READY=0 while stalled, the LRC uses the latched even mode, and no words are lost or duplicated.
- Reset mid-block: FRAME_LEN=4, send 2 words, pulse RST low -> all outputs 0, BUSY=0. A new block of 4 words (0x10,0x20,0x40,0x80) yields LRC 0xF0 with OUT_PAR=0, with no carry-over from the aborted block.
- Max frame: FRAME_W=4, FRAME_LEN=15, send 15 words of 0xFF -> the LRC word is 0xFF, emitted after word 15, and the counter returns to 0.
